// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage RISC-V pipeline: drives the data-memory bus for
// loads/stores, formats load data, flags misaligned accesses and passes ALU results through.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [31:0]       i_rs_2,
  input  logic [4:0]        i_rd_num,
  input  logic [31:0]       i_alu_out,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_func_3,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              o_valid,
  output logic [4:0]        o_rd_num,
  output logic [31:0]       o_wb_data,
  output logic              o_reg_write,
  output logic              o_misaligned
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        is_writer;
  logic        misaligned;
  logic        start;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  // Context of the outstanding access, kept so the EX/MEM inputs are not needed on completion.
  logic [4:0]  busy_rd;
  logic        busy_load;
  logic [2:0]  busy_f3;
  logic [1:0]  busy_lo;

  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  always_comb begin
    is_load   = (i_opcode == OP_LOAD);
    is_store  = (i_opcode == OP_STORE);
    is_mem    = is_load | is_store;
    is_writer = 1'b0;
    case (i_opcode)
      OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD: is_writer = 1'b1;
      default:                                                   is_writer = 1'b0;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (i_func_3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = is_mem & i_alu_out[0];
      default: misaligned = is_mem & (i_alu_out[1:0] != 2'b00);
    endcase
    start = i_valid & is_mem & ~misaligned;
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = i_rs_2;
    case (i_func_3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << i_alu_out[1:0];
        st_wdata = {4{i_rs_2[7:0]}};
      end
      2'b01: begin
        st_be    = i_alu_out[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{i_rs_2[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = i_rs_2;
      end
    endcase
  end

  always_comb begin
    ld_shift = dmem_rdata >> {busy_lo, 3'b000};
    ld_data  = dmem_rdata;
    case (busy_f3[1:0])
      2'b00:   ld_data = busy_f3[2] ? {24'h0, ld_shift[7:0]}
                                    : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_data = busy_f3[2] ? {16'h0, ld_shift[15:0]}
                                    : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  assign stall = (state == IDLE) ? start : ~dmem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      busy_rd      <= '0;
      busy_load    <= 1'b0;
      busy_f3      <= '0;
      busy_lo      <= '0;
      o_valid      <= 1'b0;
      o_rd_num     <= '0;
      o_wb_data    <= '0;
      o_reg_write  <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_misaligned <= i_valid & misaligned;
          if (start) begin
            state       <= BUSY;
            dmem_req    <= 1'b1;
            dmem_we     <= is_store;
            dmem_addr   <= {i_alu_out[ADDR_W-1:2], 2'b00};
            dmem_be     <= is_store ? st_be : 4'b1111;
            dmem_wdata  <= is_store ? st_wdata : '0;
            busy_rd     <= i_rd_num;
            busy_load   <= is_load;
            busy_f3     <= i_func_3;
            busy_lo     <= i_alu_out[1:0];
            o_valid     <= 1'b0;
            o_reg_write <= 1'b0;
          end else begin
            o_valid     <= i_valid;
            o_rd_num    <= i_rd_num;
            o_wb_data   <= i_alu_out;
            o_reg_write <= i_valid & is_writer & (i_rd_num != 5'd0) & ~misaligned;
          end
        end
        BUSY: begin
          o_misaligned <= 1'b0;
          if (dmem_ready) begin
            state       <= IDLE;
            dmem_req    <= 1'b0;
            o_valid     <= 1'b1;
            o_rd_num    <= busy_rd;
            o_wb_data   <= busy_load ? ld_data : '0;
            o_reg_write <= busy_load & (busy_rd != 5'd0);
          end else begin
            o_valid     <= 1'b0;
            o_reg_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scenario tasks drive EX/MEM slots and play the memory;
// a negedge monitor pops expected writeback slots from a scoreboard queue.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_rs_2;
  logic [4:0]  i_rd_num;
  logic [31:0] i_alu_out;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func_3;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        o_valid;
  logic [4:0]  o_rd_num;
  logic [31:0] o_wb_data;
  logic        o_reg_write;
  logic        o_misaligned;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_rs_2(i_rs_2), .i_rd_num(i_rd_num),
    .i_alu_out(i_alu_out), .i_opcode(i_opcode), .i_func_3(i_func_3), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .o_valid(o_valid), .o_rd_num(o_rd_num), .o_wb_data(o_wb_data),
    .o_reg_write(o_reg_write), .o_misaligned(o_misaligned)
  );

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wb;
    logic        regw;
    logic        mis;
    logic        chk_wb;
  } slot_t;

  slot_t exp_q[$];
  int    tests  = 0;
  int    failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void expect_slot(input logic [4:0] rd, input logic [31:0] wb,
                                      input logic regw, input logic mis, input logic chk_wb);
    slot_t s;
    s.rd = rd; s.wb = wb; s.regw = regw; s.mis = mis; s.chk_wb = chk_wb;
    exp_q.push_back(s);
  endfunction

  // Scoreboard: every valid output slot must match the oldest expected slot, bubbles stay inert.
  always @(negedge clk) begin
    slot_t e;
    if (!rst) begin
      if (o_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL sb_unexpected_slot: got rd=%0d wb=%h regw=%b mis=%b, expected no slot",
                   o_rd_num, o_wb_data, o_reg_write, o_misaligned);
        end else begin
          e = exp_q.pop_front();
          if (o_rd_num !== e.rd || o_reg_write !== e.regw || o_misaligned !== e.mis ||
              (e.chk_wb && o_wb_data !== e.wb)) begin
            failed++;
            $display("FAIL sb_slot: got rd=%0d wb=%h regw=%b mis=%b, expected rd=%0d wb=%h regw=%b mis=%b",
                     o_rd_num, o_wb_data, o_reg_write, o_misaligned, e.rd, e.wb, e.regw, e.mis);
          end
        end
      end else begin
        tests++;
        if (o_reg_write !== 1'b0 || o_misaligned !== 1'b0) begin
          failed++;
          $display("FAIL sb_bubble: got regw=%b mis=%b, expected 0 0", o_reg_write, o_misaligned);
        end
      end
    end
  end

  // Drives one EX/MEM slot, acts as memory (ready after `waits` BUSY cycles) and reports bus activity.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] rs2, input logic [4:0] rd, input int waits,
                        input logic [31:0] rdata, output int stalls, output logic req_seen,
                        output logic we_c, output logic [31:0] addr_c, output logic [3:0] be_c,
                        output logic [31:0] wd_c, output logic stable, output logic done);
    int busy;
    busy = 0; stalls = 0; req_seen = 1'b0; stable = 1'b1; done = 1'b0;
    we_c = 1'b0; addr_c = '0; be_c = '0; wd_c = '0;
    i_valid = 1'b1; i_opcode = op; i_func_3 = f3; i_alu_out = alu; i_rs_2 = rs2; i_rd_num = rd;
    for (int c = 0; c < 40 && !done; c++) begin
      if (dmem_req) begin
        if (!req_seen) begin
          we_c = dmem_we; addr_c = dmem_addr; be_c = dmem_be; wd_c = dmem_wdata;
        end else if (we_c !== dmem_we || addr_c !== dmem_addr || be_c !== dmem_be ||
                     wd_c !== dmem_wdata) begin
          stable = 1'b0;
        end
        req_seen = 1'b1;
        if (busy == waits) begin
          dmem_ready = 1'b1;
          dmem_rdata = rdata;
        end
        busy++;
      end
      #1;
      if (stall) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
      dmem_rdata = 32'hDEAD_0000;
    end
    i_valid = 1'b0;
  endtask

  task automatic test_reset;
    tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, o_valid, o_rd_num, o_wb_data,
         o_reg_write, o_misaligned, stall} !== '0) begin
      failed++;
      $display("FAIL reset_values: req=%b we=%b addr=%h be=%b wd=%h ov=%b rd=%0d wb=%h rw=%b mis=%b stall=%b, expected all 0",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, o_valid, o_rd_num,
               o_wb_data, o_reg_write, o_misaligned, stall);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu;
    int st; logic rq, we, stb, dn; logic [31:0] a, wd; logic [3:0] be;
    expect_slot(5'd5, 32'h1234, 1'b1, 1'b0, 1'b1);
    run_op(OP_REG, 3'b000, 32'h1234, 32'h0, 5'd5, 0, 32'h0, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (st !== 0 || rq !== 1'b0 || dn !== 1'b1) begin
      failed++;
      $display("FAIL alu_rd5: stalls=%0d req=%b done=%b, expected 0 0 1", st, rq, dn);
    end
    expect_slot(5'd0, 32'h1234, 1'b0, 1'b0, 1'b1);
    run_op(OP_REG, 3'b000, 32'h1234, 32'h0, 5'd0, 0, 32'h0, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (st !== 0 || rq !== 1'b0) begin
      failed++;
      $display("FAIL alu_rd0: stalls=%0d req=%b, expected 0 0", st, rq);
    end
    // OP-IMM with func_3 that would look misaligned for a memory op
    expect_slot(5'd31, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    run_op(OP_IMM, 3'b010, 32'hFFFF_FFFF, 32'h0, 5'd31, 0, 32'h0, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (st !== 0 || rq !== 1'b0) begin
      failed++;
      $display("FAIL alu_imm: stalls=%0d req=%b, expected 0 0", st, rq);
    end
  endtask

  task automatic test_loads;
    int st; logic rq, we, stb, dn; logic [31:0] a, wd; logic [3:0] be;
    expect_slot(5'd10, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1);
    run_op(OP_LOAD, 3'b000, 32'h103, 32'h0, 5'd10, 0, 32'h80AA_55CC, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (st !== 1 || rq !== 1'b1 || we !== 1'b0 || a !== 32'h100 || be !== 4'b1111 || dn !== 1'b1) begin
      failed++;
      $display("FAIL lb_bus: stalls=%0d req=%b we=%b addr=%h be=%b, expected 1 1 0 00000100 1111",
               st, rq, we, a, be);
    end
    expect_slot(5'd11, 32'h0000_0080, 1'b1, 1'b0, 1'b1);
    run_op(OP_LOAD, 3'b100, 32'h103, 32'h0, 5'd11, 0, 32'h80AA_55CC, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (st !== 1 || a !== 32'h100) begin
      failed++;
      $display("FAIL lbu_bus: stalls=%0d addr=%h, expected 1 00000100", st, a);
    end
    expect_slot(5'd12, 32'hFFFF_8001, 1'b1, 1'b0, 1'b1);
    run_op(OP_LOAD, 3'b001, 32'h402, 32'h0, 5'd12, 2, 32'h8001_7F7F, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (st !== 3 || a !== 32'h400 || stb !== 1'b1) begin
      failed++;
      $display("FAIL lh_bus: stalls=%0d addr=%h stable=%b, expected 3 00000400 1", st, a, stb);
    end
    expect_slot(5'd13, 32'h0000_8001, 1'b1, 1'b0, 1'b1);
    run_op(OP_LOAD, 3'b101, 32'h402, 32'h0, 5'd13, 0, 32'h8001_7F7F, st, rq, we, a, be, wd, stb, dn);
    expect_slot(5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op(OP_LOAD, 3'b010, 32'h500, 32'h0, 5'd0, 0, 32'h1111_2222, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (st !== 1 || rq !== 1'b1) begin
      failed++;
      $display("FAIL lw_rd0_bus: stalls=%0d req=%b, expected 1 1", st, rq);
    end
  endtask

  task automatic test_stores;
    int st; logic rq, we, stb, dn; logic [31:0] a, wd; logic [3:0] be;
    expect_slot(5'd4, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op(OP_STORE, 3'b001, 32'h202, 32'hDEAD_BEEF, 5'd4, 3, 32'h0, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (st !== 4 || we !== 1'b1 || a !== 32'h200 || be !== 4'b1100 || wd !== 32'hBEEF_BEEF ||
        stb !== 1'b1 || dn !== 1'b1) begin
      failed++;
      $display("FAIL sh_bus: stalls=%0d we=%b addr=%h be=%b wd=%h stable=%b, expected 4 1 00000200 1100 beefbeef 1",
               st, we, a, be, wd, stb);
    end
    expect_slot(5'd4, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op(OP_STORE, 3'b000, 32'h201, 32'h1234_56A5, 5'd4, 1, 32'h0, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (st !== 2 || be !== 4'b0010 || wd !== 32'hA5A5_A5A5 || a !== 32'h200) begin
      failed++;
      $display("FAIL sb_bus: stalls=%0d be=%b wd=%h addr=%h, expected 2 0010 a5a5a5a5 00000200",
               st, be, wd, a);
    end
    expect_slot(5'd4, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op(OP_STORE, 3'b010, 32'h20C, 32'hCAFE_F00D, 5'd4, 0, 32'h0, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (be !== 4'b1111 || wd !== 32'hCAFE_F00D || a !== 32'h20C) begin
      failed++;
      $display("FAIL sw_bus: be=%b wd=%h addr=%h, expected 1111 cafef00d 0000020c", be, wd, a);
    end
  endtask

  task automatic test_misaligned;
    int st; logic rq, we, stb, dn; logic [31:0] a, wd; logic [3:0] be;
    expect_slot(5'd6, 32'h105, 1'b0, 1'b1, 1'b1);
    run_op(OP_LOAD, 3'b010, 32'h105, 32'h0, 5'd6, 0, 32'h0, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (st !== 0 || rq !== 1'b0) begin
      failed++;
      $display("FAIL lw_misaligned: stalls=%0d req=%b, expected 0 0", st, rq);
    end
    expect_slot(5'd2, 32'h303, 1'b0, 1'b1, 1'b1);
    run_op(OP_STORE, 3'b001, 32'h303, 32'h55, 5'd2, 0, 32'h0, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (st !== 0 || rq !== 1'b0) begin
      failed++;
      $display("FAIL sh_misaligned: stalls=%0d req=%b, expected 0 0", st, rq);
    end
  endtask

  task automatic test_bubble;
    i_valid = 1'b0; i_opcode = OP_LOAD; i_func_3 = 3'b010; i_alu_out = 32'h600;
    dmem_ready = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b0) begin
      failed++;
      $display("FAIL bubble_stall: got %b, expected 0", stall);
    end
    repeat (2) @(posedge clk);
    #1;
    dmem_ready = 1'b0;
    tests++;
    if (dmem_req !== 1'b0 || o_valid !== 1'b0) begin
      failed++;
      $display("FAIL bubble_no_access: req=%b o_valid=%b, expected 0 0", dmem_req, o_valid);
    end
  endtask

  task automatic test_back_to_back;
    int st; logic rq, we, stb, dn; logic [31:0] a, wd; logic [3:0] be;
    expect_slot(5'd8, 32'h1122_3344, 1'b1, 1'b0, 1'b1);
    expect_slot(5'd9, 32'h0000_0077, 1'b1, 1'b0, 1'b1);
    run_op(OP_LOAD, 3'b010, 32'h104, 32'h0, 5'd8, 1, 32'h1122_3344, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (o_valid !== 1'b1 || o_rd_num !== 5'd8) begin
      failed++;
      $display("FAIL b2b_lw_edge: o_valid=%b rd=%0d, expected 1 8", o_valid, o_rd_num);
    end
    run_op(OP_REG, 3'b000, 32'h77, 32'h0, 5'd9, 0, 32'h0, st, rq, we, a, be, wd, stb, dn);
    tests++;
    if (o_valid !== 1'b1 || o_rd_num !== 5'd9 || st !== 0) begin
      failed++;
      $display("FAIL b2b_add_edge: o_valid=%b rd=%0d stalls=%0d, expected 1 9 0", o_valid, o_rd_num, st);
    end
  endtask

  task automatic test_reset_busy;
    i_valid = 1'b1; i_opcode = OP_LOAD; i_func_3 = 3'b010; i_alu_out = 32'h300; i_rd_num = 5'd7;
    @(posedge clk); #1;
    tests++;
    if (dmem_req !== 1'b1) begin
      failed++;
      $display("FAIL rst_busy_enter: req=%b, expected 1", dmem_req);
    end
    rst = 1'b1;
    i_valid = 1'b0;
    #1;
    tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, o_valid, o_rd_num, o_wb_data,
         o_reg_write, o_misaligned} !== '0) begin
      failed++;
      $display("FAIL rst_busy_clear: req=%b addr=%h be=%b ov=%b rw=%b, expected all 0",
               dmem_req, dmem_addr, dmem_be, o_valid, o_reg_write);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_ready = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (dmem_req !== 1'b0 || o_valid !== 1'b0 || o_reg_write !== 1'b0) begin
      failed++;
      $display("FAIL rst_busy_ready_ignored: req=%b o_valid=%b rw=%b, expected 0 0 0",
               dmem_req, o_valid, o_reg_write);
    end
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_rs_2 = '0; i_rd_num = '0; i_alu_out = '0;
    i_opcode = '0; i_func_3 = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_alu;
    test_loads;
    test_stores;
    test_misaligned;
    test_bubble;
    test_back_to_back;
    repeat (3) @(posedge clk);
    #1;
    test_reset_busy;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL sb_drain: %0d expected slots never produced, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
